mips_inst_encoder: RTL and testbench
====================================

Name: mips_inst_encoder

Overview:
- Instruction-side counterpart to the control decoder in the MIPS R/I/J core.
- Accepts symbolic instructions (mnemonic plus register, immediate and target fields) over a valid/ready stream.
- Packs each one into a 32-bit MIPS word and writes it into instruction memory at sequential word addresses.
- Used by the bench and boot logic to load programs that the core then fetches and decodes.

Parameters:
- ADDR_W, 6: instruction memory word-address width; depth is 2^ADDR_W.
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session at BASE_ADDR.
- finish  input  1  ends the session.
- in_valid  input  1  instruction beat valid.
- in_ready  output  1  encoder can accept a beat.
- mnem  input  5  mnemonic code, see Behaviour.
- rs  input  5  rs field.
- rt  input  5  rt field.
- rd  input  5  rd field.
- imm  input  16  immediate / branch offset.
- target  input  26  jump target.
- Inst_Write  output  1  memory write strobe.
- Inst_Addr  output  ADDR_W  memory word address.
- Inst_Data  output  32  encoded instruction.
- count  output  ADDR_W+1  words written this session.
- busy  output  1  session active (LOAD or WRITE).
- full  output  1  memory filled; sticky until start or reset.
- done  output  1  one-cycle pulse on session end.
- err  output  1  sticky; an illegal mnemonic was received.

Behaviour:
- Reset (rst_n=0 at clk edge), all outputs 0:
  - Inst_Write, Inst_Addr, Inst_Data, count, busy, full, done, err and in_ready are 0.
  - State goes to IDLE.
  - A pending write is dropped.
- Mnemonic map (0-18); anything else is illegal:
  - R-type, word {000000,rs,rt,rd,00000,funct}:
    - 0 ADD, funct 100000
    - 1 SUB, funct 100010
    - 2 AND, funct 100100
    - 3 OR, funct 100101
    - 4 XOR, funct 100110
    - 5 NOR, funct 100111
    - 6 SLTU, funct 101011
    - 7 SLLV, funct 000100
  - 8 JR: rt and rd are forced to 0, funct 001000.
  - I-type, word {op,rs,rt,imm}:
    - 9 ADDI, op 001000
    - 10 ANDI, op 001100
    - 11 XORI, op 001110
    - 12 SLTIU, op 001011
    - 13 LW, op 100011
    - 14 SW, op 101011
    - 15 BEQ, op 000100
    - 16 BNE, op 000101
  - J-type, word {op,target}:
    - 17 J, op 000010
    - 18 JAL, op 000011
- FSM states: IDLE, LOAD, WRITE, FULL, DONE.
  - IDLE:
    - in_ready=0.
    - On start: addr<=BASE_ADDR, count<=0, full<=0, err<=0, go to LOAD.
  - LOAD:
    - in_ready=1, busy=1.
    - A beat is accepted when in_valid&in_ready.
    - Legal beat: Inst_Data and Inst_Addr are registered and the FSM goes to WRITE.
    - Illegal beat: err<=1, nothing is written, the FSM stays in LOAD.
    - finish with no beat accepted: go to DONE.
  - WRITE:
    - Inst_Write=1 for exactly one cycle and in_ready=0.
    - addr and count increment.
    - If the written address was 2^ADDR_W-1: full<=1, go to FULL.
    - Else, if finish is pending: go to DONE.
    - Else: go to LOAD.
  - FULL:
    - in_ready=0; further beats are not accepted.
    - On finish: go to DONE.
  - DONE:
    - done=1 for one cycle, then IDLE.
    - count, full and err are held until the next start.
- Latency: accept edge to Inst_Write high is 1 cycle. Peak throughput is one word per 2 cycles.
- finish arriving together with an accepted beat is latched as pending. The beat is written first, then the FSM goes to DONE.
- start outside IDLE is ignored.
- Address wraps are never taken; FULL blocks them.
- Inst_Data and Inst_Addr hold their last value when Inst_Write=0.
- Reset in any state forces IDLE on the next edge with all outputs 0.

Optional Feature:
- Macro: ENC_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0].
  - checksum is cleared on start and on reset.
  - It is XORed with Inst_Data on every Inst_Write cycle.
  - It is valid and stable from the done pulse onward.
- When undefined: the port and its logic are absent.

Test Plan:
- Reset then start; beat ADD rs=1, rt=2, rd=3 -> one cycle later Inst_Write=1, Inst_Addr=0, Inst_Data=0x00221820; count=1.
- Beats ADDI rs=0, rt=4, imm=0xFFFF, then J target=0x0000010 -> Inst_Data 0x2004FFFF at addr 0, then 0x08000010 at addr 1.
- Beat mnem=25 -> err=1, no Inst_Write, in_ready stays 1. Next beat JR rs=31 -> 0x03E00008 written.
- With ADDR_W=2, send 5 beats -> 4 writes at addresses 0-3, full=1, 5th beat not accepted. finish -> done pulse, count=4.
- finish asserted in the same cycle as an accepted SW rs=2, rt=5, imm=8 beat -> 0xAC450008 written, then done next cycle.
- rst_n low during WRITE -> next edge all outputs 0 and state IDLE. With ENC_CHECKSUM_EN, checksum after writing 0x00221820 and 0x2004FFFF is 0x2026E7DF.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// Packs symbolic MIPS R/I/J instructions into 32-bit words and writes them to instruction memory.
// Optional running XOR checksum of written words is enabled with ENC_CHECKSUM_EN.
module mips_inst_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              Inst_Write,
    output logic [ADDR_W-1:0] Inst_Addr,
    output logic [31:0]       Inst_Data,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_FULL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A    = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    // Returns {legal, word}; an illegal mnemonic yields legal=0 and a zero word.
    function automatic logic [32:0] encode(
        input logic [4:0]  m,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_tgt
    );
        logic [5:0]  fn;
        logic [5:0]  op;
        logic [32:0] res;
        fn  = 6'b000000;
        op  = 6'b000000;
        res = 33'd0;
        case (m)
            5'd0:    fn = 6'b100000;
            5'd1:    fn = 6'b100010;
            5'd2:    fn = 6'b100100;
            5'd3:    fn = 6'b100101;
            5'd4:    fn = 6'b100110;
            5'd5:    fn = 6'b100111;
            5'd6:    fn = 6'b101011;
            5'd7:    fn = 6'b000100;
            5'd9:    op = 6'b001000;
            5'd10:   op = 6'b001100;
            5'd11:   op = 6'b001110;
            5'd12:   op = 6'b001011;
            5'd13:   op = 6'b100011;
            5'd14:   op = 6'b101011;
            5'd15:   op = 6'b000100;
            5'd16:   op = 6'b000101;
            5'd17:   op = 6'b000010;
            5'd18:   op = 6'b000011;
            default: fn = 6'b000000;
        endcase
        if (m <= 5'd7) begin
            res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'b00000, fn};
        end else if (m == 5'd8) begin
            res = {1'b1, 6'b000000, f_rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
        end else if (m <= 5'd16) begin
            res = {1'b1, op, f_rs, f_rt, f_imm};
        end else if (m <= 5'd18) begin
            res = {1'b1, op, f_tgt};
        end else begin
            res = 33'd0;
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         data_q, data_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                pend_q, pend_d;
    logic                wr_q, wr_d;
    logic                rdy_q, rdy_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept_s;
    logic [32:0]         enc_s;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]         csum_q, csum_d;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        waddr_d  = waddr_q;
        count_d  = count_q;
        data_d   = data_q;
        full_d   = full_q;
        err_d    = err_q;
        pend_d   = pend_q;
        accept_s = in_valid & rdy_q;
        enc_s    = encode(mnem, rs, rt, rd, imm, target);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = BASE_A;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s && enc_s[32]) begin
                    data_d  = enc_s[31:0];
                    waddr_d = addr_q;
                    pend_d  = finish;
                    state_d = S_WRITE;
                end else begin
                    if (accept_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (finish) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_ONE;
                count_d = count_q + COUNT_ONE;
                // The last slot blocks further writes so the address never wraps.
                if (waddr_q == ADDR_LAST) begin
                    full_d  = 1'b1;
                    state_d = S_FULL;
                end else if (pend_q || finish) begin
                    pend_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FULL: begin
                if (finish || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FULL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        wr_d   = (state_d == S_WRITE);
        rdy_d  = (state_d == S_LOAD);
        busy_d = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
`ifdef ENC_CHECKSUM_EN
        csum_d = csum_q;
        if ((state_q == S_IDLE) && start) begin
            csum_d = 32'd0;
        end else if (wr_q) begin
            csum_d = csum_q ^ data_q;
        end else begin
            csum_d = csum_q;
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            count_q <= '0;
            data_q  <= 32'd0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            csum_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            data_q  <= data_d;
            full_q  <= full_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ENC_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign in_ready   = rdy_q;
    assign Inst_Write = wr_q;
    assign Inst_Addr  = waddr_q;
    assign Inst_Data  = data_q;
    assign count      = count_q;
    assign busy       = busy_q;
    assign full       = full_q;
    assign done       = done_q;
    assign err        = err_q;
`ifdef ENC_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Self-checking bench for mips_inst_encoder: vector table, hand sequences and random sessions
// against an arithmetic encoding model. Checks checksum too when ENC_CHECKSUM_EN is defined.
module tb_mips_inst_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, finish, in_valid;
    logic [4:0]    mnem, rs, rt, rd;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          in_ready, Inst_Write, busy, full, done, err;
    logic [AW-1:0] Inst_Addr;
    logic [31:0]   Inst_Data;
    logic [AW:0]   count;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    mips_inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .Inst_Write(Inst_Write), .Inst_Addr(Inst_Addr), .Inst_Data(Inst_Data),
        .count(count), .busy(busy), .full(full), .done(done), .err(err)
`ifdef ENC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    typedef struct {
        logic [4:0]  m;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [15:0] im;
        logic [25:0] tg;
        logic        fin;
        logic [31:0] ew;
        logic        el;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          m_count;
    logic        m_err, m_full;
    logic [31:0] m_csum;
    int          fn_tab[8];
    int          op_tab[8];
    vec_t        tv[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: field values placed at their bit positions by multiplication by powers of two.
    function automatic logic [32:0] ref_enc(input logic [4:0] m, input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] c, input logic [15:0] im, input logic [25:0] tg);
        longint unsigned w;
        int mi;
        mi = int'(m);
        if (mi < 8)       w = longint'(a) * 2097152 + longint'(b) * 65536 + longint'(c) * 2048 + longint'(fn_tab[mi]);
        else if (mi == 8) w = longint'(a) * 2097152 + 8;
        else if (mi < 17) w = longint'(op_tab[mi-9]) * 67108864 + longint'(a) * 2097152 + longint'(b) * 65536 + longint'(im);
        else if (mi < 19) w = longint'(mi - 15) * 67108864 + longint'(tg);
        else return 33'd0;
        return {1'b1, w[31:0]};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_wr"}, Inst_Write, 0);
        chk({tag, "_addr"}, Inst_Addr, 0);
        chk({tag, "_data"}, Inst_Data, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdy"}, in_ready, 0);
`ifdef ENC_CHECKSUM_EN
        chk({tag, "_csum"}, checksum, 0);
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_count = 0; m_err = 1'b0; m_full = 1'b0; m_csum = 32'd0;
        chk("start_busy", busy, 1);
        chk("start_rdy", in_ready, 1);
        chk("start_count", count, 0);
        chk("start_err", err, 0);
        chk("start_full", full, 0);
    endtask

    // Called in the cycle where done should be high.
    task automatic session_done();
        chk("done_pulse", done, 1);
        chk("done_count", count, m_count);
        chk("done_full", full, m_full);
        chk("done_err", err, m_err);
`ifdef ENC_CHECKSUM_EN
        chk("done_csum", checksum, m_csum);
`endif
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rdy", in_ready, 0);
        chk("idle_count", count, m_count);
    endtask

    task automatic end_session();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        session_done();
    endtask

    task automatic beat(input logic [4:0] m, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [15:0] im, input logic [25:0] tg, input logic fin,
                        input logic [31:0] ew, input logic el);
        chk("rdy_before", in_ready, 1);
        in_valid = 1'b1; mnem = m; rs = a; rt = b; rd = c; imm = im; target = tg; finish = fin;
        @(posedge clk); #1;
        in_valid = 1'b0; finish = 1'b0;
        if (el) begin
            chk("wr_high", Inst_Write, 1);
            chk("wr_addr", Inst_Addr, m_count);
            chk("wr_data", Inst_Data, ew);
            chk("wr_rdy", in_ready, 0);
            m_count++;
            m_csum = m_csum ^ ew;
            @(posedge clk); #1;
            chk("wr_low", Inst_Write, 0);
            chk("wr_hold", Inst_Data, ew);
            chk("wr_count", count, m_count);
            if (m_count == DEPTH) begin
                m_full = 1'b1;
                chk("full_set", full, 1);
                chk("full_rdy", in_ready, 0);
            end else if (fin) begin
                chk("fin_rdy", in_ready, 0);
                session_done();
            end else begin
                chk("load_rdy", in_ready, 1);
            end
        end else begin
            m_err = 1'b1;
            chk("ill_wr", Inst_Write, 0);
            chk("ill_err", err, 1);
            chk("ill_rdy", in_ready, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [32:0] r;
        logic        active;
        int          nb;
        logic [4:0]  ra, rb, rc, rm;
        logic [15:0] rim;
        logic [25:0] rtg;

        fn_tab = '{32, 34, 36, 37, 38, 39, 43, 4};
        op_tab = '{8, 12, 14, 11, 35, 43, 4, 5};
        tv[0] = '{5'd0,  5'd1,  5'd2,  5'd3, 16'h0000, 26'h0,       1'b0, 32'h00221820, 1'b1};
        tv[1] = '{5'd9,  5'd0,  5'd4,  5'd0, 16'hFFFF, 26'h0,       1'b0, 32'h2004FFFF, 1'b1};
        tv[2] = '{5'd17, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h0000010, 1'b0, 32'h08000010, 1'b1};
        tv[3] = '{5'd25, 5'd3,  5'd3,  5'd3, 16'h1234, 26'h0,       1'b0, 32'h00000000, 1'b0};
        tv[4] = '{5'd8,  5'd31, 5'd7,  5'd7, 16'h0000, 26'h0,       1'b0, 32'h03E00008, 1'b1};
        tv[5] = '{5'd7,  5'd5,  5'd6,  5'd7, 16'h0000, 26'h0,       1'b0, 32'h00A63804, 1'b1};
        tv[6] = '{5'd19, 5'd1,  5'd1,  5'd1, 16'h0001, 26'h1,       1'b0, 32'h00000000, 1'b0};
        tv[7] = '{5'd14, 5'd2,  5'd5,  5'd0, 16'h0008, 26'h0,       1'b1, 32'hAC450008, 1'b1};
        tv[8] = '{5'd18, 5'd0,  5'd0,  5'd0, 16'h0000, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF, 1'b1};
        tv[9] = '{5'd16, 5'd31, 5'd31, 5'd0, 16'h8000, 26'h0,       1'b0, 32'h17FF8000, 1'b1};

        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        mnem = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Table: sessions restart after a finish or once memory is full.
        active = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!active) begin
                do_start();
                active = 1'b1;
            end
            beat(tv[i].m, tv[i].a, tv[i].b, tv[i].c, tv[i].im, tv[i].tg, tv[i].fin, tv[i].ew, tv[i].el);
            if (tv[i].fin && tv[i].el) begin
                active = 1'b0;
            end else if (m_count == DEPTH) begin
                end_session();
                active = 1'b0;
            end
        end
        if (active) end_session();

        // start inside a session is ignored; checksum keeps accumulating.
        do_start();
        beat(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h00221820, 1'b1);
        beat(5'd9, 5'd0, 5'd4, 5'd0, 16'hFFFF, 26'h0, 1'b0, 32'h2004FFFF, 1'b1);
`ifdef ENC_CHECKSUM_EN
        chk("csum_const", checksum, 32'h2026E7DF);
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_start_count", count, 2);
        chk("ign_start_rdy", in_ready, 1);
        beat(5'd17, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b0, 32'h08000010, 1'b1);
        end_session();

        // Fill memory, then a fifth beat must not be accepted.
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            r = ref_enc(5'(i + 10), 5'(i), 5'(i + 1), 5'd0, 16'(i * 257), 26'd0);
            beat(5'(i + 10), 5'(i), 5'(i + 1), 5'd0, 16'(i * 257), 26'd0, 1'b0, r[31:0], r[32]);
        end
        in_valid = 1'b1; mnem = 5'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("full_nowr", Inst_Write, 0);
            chk("full_rdy_hold", in_ready, 0);
            chk("full_count", count, DEPTH);
        end
        in_valid = 1'b0;
        end_session();

        // Reset while a write is in flight.
        do_start();
        in_valid = 1'b1; mnem = 5'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_wr", Inst_Write, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero("rst_write");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_zero("post_rst");

        // Random sessions against the reference model.
        for (int s = 0; s < 8; s++) begin
            do_start();
            nb = $urandom_range(1, 7);
            for (int k = 0; k < nb; k++) begin
                if (m_count < DEPTH) begin
                    rm  = 5'($urandom_range(0, 22));
                    ra  = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom);
                    rim = 16'($urandom); rtg = 26'($urandom);
                    r   = ref_enc(rm, ra, rb, rc, rim, rtg);
                    beat(rm, ra, rb, rc, rim, rtg, 1'b0, r[31:0], r[32]);
                end
            end
            end_session();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
